// File: rtl/dec_scan_seq_if.sv
// Control/status bundle between a scan controller and the dec_scan_seq index generator.
// The sequencer takes the slave side; whoever issues start/stop and mode/div takes the master side.
interface dec_scan_seq_if #(
  parameter int DIV_W = 8
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [2:0]       sel;
  logic             en;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
    output start, stop, mode, div,
    input  sel, en, busy, wrap, done
  );

  modport slave (
    input  start, stop, mode, div,
    output sel, en, busy, wrap, done
  );
endinterface

// File: rtl/dec_scan_seq.sv
// Programmable 3-bit scan sequencer driving index/enable of a 3-to-8 decoder.
// Patterns: up, down, bounce and single-shot up, with a programmable dwell of div+1 cycles per index.
module dec_scan_seq #(
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dec_scan_seq_if.slave        bus_if
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MD_UP     = 2'b00,
    MD_DOWN   = 2'b01,
    MD_BOUNCE = 2'b10,
    MD_SINGLE = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  mode_t            mode_l_q, mode_l_d;
  logic             dir_dn_q, dir_dn_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (state_q == ST_RUN) && (cnt_q == div_l_q);

  // Bounce turns around at the endpoints so 0 and 7 each appear for a single dwell.
  function automatic logic [3:0] bounce_step(input logic [2:0] cur, input logic dn);
    logic [2:0] nxt;
    logic       ndn;
    if (!dn) begin
      if (cur == 3'd7) begin
        nxt = 3'd6;
        ndn = 1'b1;
      end else begin
        nxt = cur + 3'd1;
        ndn = 1'b0;
      end
    end else begin
      if (cur == 3'd0) begin
        nxt = 3'd1;
        ndn = 1'b0;
      end else begin
        nxt = cur - 3'd1;
        ndn = 1'b1;
      end
    end
    return {ndn, nxt};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= '0;
      div_l_q  <= '0;
      mode_l_q <= MD_UP;
      dir_dn_q <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      div_l_q  <= div_l_d;
      mode_l_q <= mode_l_d;
      dir_dn_q <= dir_dn_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    logic [3:0] bstep;
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    div_l_d  = div_l_q;
    mode_l_d = mode_l_q;
    dir_dn_d = dir_dn_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    bstep    = bounce_step(sel_q, dir_dn_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.start && !bus_if.stop) begin
          state_d  = ST_RUN;
          mode_l_d = mode_t'(bus_if.mode);
          div_l_d  = bus_if.div;
          cnt_d    = '0;
          dir_dn_d = (bus_if.mode == MD_DOWN);
          sel_d    = (bus_if.mode == MD_DOWN) ? 3'd7 : 3'd0;
        end
      end

      ST_RUN: begin
        // stop outranks any coincident tick: sel freezes and no status pulse is issued.
        if (bus_if.stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = '0;
          unique case (mode_l_q)
            MD_UP: begin
              sel_d  = sel_q + 3'd1;
              wrap_d = (sel_q == 3'd7);
            end
            MD_DOWN: begin
              sel_d  = sel_q - 3'd1;
              wrap_d = (sel_q == 3'd0);
            end
            MD_BOUNCE: begin
              sel_d    = bstep[2:0];
              dir_dn_d = bstep[3];
              wrap_d   = dir_dn_q && (sel_q == 3'd1);
            end
            MD_SINGLE: begin
              if (sel_q == 3'd7) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                sel_d = sel_q + 3'd1;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.sel  = sel_q;
  assign bus_if.en   = (state_q == ST_RUN);
  assign bus_if.busy = (state_q == ST_RUN);
  assign bus_if.wrap = wrap_q;
  assign bus_if.done = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq: reset/idle, up, divided down, bounce, single-shot,
// start/stop priority and asynchronous reset mid-scan.
module tb_dec_scan_seq;

  localparam int DIV_W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dec_scan_seq_if #(.DIV_W(DIV_W)) bus ();

  dec_scan_seq #(.DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int e_sel, input int e_en,
                         input int e_wrap, input int e_done);
    chk({tag, ".sel"},  32'(bus.sel),  32'(e_sel));
    chk({tag, ".en"},   32'(bus.en),   32'(e_en));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e_en));
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(e_wrap));
    chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [DIV_W-1:0] d);
    bus.mode  = m;
    bus.div   = d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic halt();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  int bounce_seq [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 2'b00;
    bus.div   = '0;

    tick();
    chk_out("reset", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("idle", 0, 0, 0, 0);
    end

    // Up, div=0: 0..7,0,1 with wrap on the 7->0 step.
    launch(2'b00, 8'd0);
    chk_out("up", 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_out("up", i % 8, 1, (i == 8) ? 1 : 0, 0);
    end
    halt();
    chk_out("up_stop", 1, 0, 0, 0);
    tick();
    tick();
    chk_out("up_frozen", 1, 0, 0, 0);

    // Down, div=2: three cycles per index; mid-run mode/div changes must be ignored.
    launch(2'b01, 8'd2);
    bus.div  = 8'd5;
    bus.mode = 2'b00;
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) tick();
      if (c < 24)       chk_out("down", 7 - c / 3, 1, 0, 0);
      else if (c == 24) chk_out("down_wrap", 7, 1, 1, 0);
      else              chk_out("down_after", 7, 1, 0, 0);
    end
    halt();
    chk_out("down_stop", 7, 0, 0, 0);

    // Bounce, div=0: endpoints held once; wrap only on the 1->0 step.
    launch(2'b10, 8'd0);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) tick();
      chk_out("bounce", bounce_seq[c], 1, (c == 14) ? 1 : 0, 0);
    end
    halt();
    chk_out("bounce_stop", 1, 0, 0, 0);

    // Single-shot, div=1: 0..7 two cycles each, then done with sel held at 7.
    launch(2'b11, 8'd1);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) tick();
      chk_out("single", c / 2, 1, 0, 0);
    end
    tick();
    chk_out("single_done", 7, 0, 0, 1);
    tick();
    chk_out("single_idle", 7, 0, 0, 0);
    launch(2'b11, 8'd1);
    chk_out("single_restart", 0, 1, 0, 0);
    tick();
    tick();
    chk_out("single_restart2", 1, 1, 0, 0);
    halt();
    chk_out("single_stop", 1, 0, 0, 0);

    // start and stop together in IDLE must not leave IDLE.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    chk_out("startstop", 1, 0, 0, 0);
    tick();
    chk_out("startstop2", 1, 0, 0, 0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Async reset between edges while running at sel=4.
    launch(2'b00, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    chk_out("pre_rst", 4, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("post_rst", 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
